// File: rtl/addr_gen_unit.sv
// Effective-address generator for a 6502-class datapath: absolute, indexed, zero-page,
// indirect, relative and stack addressing with page-cross detection and pointer fetches.
module addr_gen_unit #(
    parameter int                DATA_W       = 8,
    parameter int                ADDR_W       = 16,
    parameter logic [DATA_W-1:0] STACK_PAGE   = 8'h01,
    parameter logic [DATA_W-1:0] SP_RESET     = 8'hFF,
    parameter bit                PAGE_PENALTY = 1'b1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic              stack_pop,
    input  logic [DATA_W-1:0] op_lo,
    input  logic [DATA_W-1:0] op_hi,
    input  logic [DATA_W-1:0] idx_x,
    input  logic [DATA_W-1:0] idx_y,
    input  logic [ADDR_W-1:0] pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] ea,
    output logic              ea_valid,
    output logic              page_cross,
    output logic              busy,
    output logic [DATA_W-1:0] sp
);

    typedef enum logic [2:0] {
        M_ABS   = 3'd0,
        M_ABS_X = 3'd1,
        M_ABS_Y = 3'd2,
        M_ZP_X  = 3'd3,
        M_IND   = 3'd4,
        M_IND_Y = 3'd5,
        M_REL   = 3'd6,
        M_STACK = 3'd7
    } mode_e;

    typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, FIX} state_e;

    localparam logic [DATA_W-1:0] ZERO_BYTE = '0;

    state_e            state;
    logic              ind_y_q;
    logic [DATA_W-1:0] ptr_hi_q;
    logic [DATA_W-1:0] op_lo_q;
    logic [DATA_W-1:0] idx_y_q;
    logic [DATA_W-1:0] lo_byte_q;
    logic [ADDR_W-1:0] fix_ea_q;

    mode_e             mode_in;
    logic [DATA_W-1:0] idx_sel;
    logic [DATA_W:0]   abs_lo_sum;
    logic [ADDR_W-1:0] abs_sum;
    logic [ADDR_W-1:0] rel_sum;
    logic              rel_cross;
    logic [DATA_W-1:0] zp_lo;
    logic [DATA_W:0]   ptr_lo_sum;
    logic [ADDR_W-1:0] ptr_sum;
    logic [DATA_W-1:0] sp_inc;
    logic [DATA_W-1:0] sp_dec;

    assign mode_in    = mode_e'(mode);
    assign idx_sel    = (mode_in == M_ABS_Y) ? idx_y : idx_x;
    assign abs_lo_sum = {1'b0, op_lo} + {1'b0, idx_sel};
    assign abs_sum    = {op_hi, op_lo} + {ZERO_BYTE, idx_sel};
    assign rel_sum    = pc + {{DATA_W{op_lo[DATA_W-1]}}, op_lo};
    assign rel_cross  = rel_sum[ADDR_W-1:DATA_W] != pc[ADDR_W-1:DATA_W];
    assign zp_lo      = op_lo + idx_x;
    // Indirect-indexed pointer: high byte arrives on mem_rdata in the RD_HI ack cycle.
    assign ptr_lo_sum = {1'b0, lo_byte_q} + {1'b0, idx_y_q};
    assign ptr_sum    = {mem_rdata, lo_byte_q} + {ZERO_BYTE, idx_y_q};
    assign sp_inc     = sp + DATA_W'(1);
    assign sp_dec     = sp - DATA_W'(1);

    assign busy = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            ea         <= '0;
            ea_valid   <= 1'b0;
            page_cross <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            sp         <= SP_RESET;
            ind_y_q    <= 1'b0;
            ptr_hi_q   <= '0;
            op_lo_q    <= '0;
            idx_y_q    <= '0;
            lo_byte_q  <= '0;
            fix_ea_q   <= '0;
        end else begin
            ea_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_lo_q <= op_lo;
                        idx_y_q <= idx_y;
                        case (mode_in)
                            M_ABS: begin
                                ea         <= {op_hi, op_lo};
                                page_cross <= 1'b0;
                                ea_valid   <= 1'b1;
                            end
                            M_ABS_X, M_ABS_Y: begin
                                if (abs_lo_sum[DATA_W] && PAGE_PENALTY) begin
                                    fix_ea_q <= abs_sum;
                                    state    <= FIX;
                                end else begin
                                    ea         <= abs_sum;
                                    page_cross <= abs_lo_sum[DATA_W];
                                    ea_valid   <= 1'b1;
                                end
                            end
                            M_ZP_X: begin
                                ea         <= {ZERO_BYTE, zp_lo};
                                page_cross <= 1'b0;
                                ea_valid   <= 1'b1;
                            end
                            M_IND, M_IND_Y: begin
                                ind_y_q  <= (mode_in == M_IND_Y);
                                ptr_hi_q <= (mode_in == M_IND_Y) ? ZERO_BYTE : op_hi;
                                mem_addr <= {(mode_in == M_IND_Y) ? ZERO_BYTE : op_hi, op_lo};
                                mem_req  <= 1'b1;
                                state    <= RD_LO;
                            end
                            M_REL: begin
                                ea         <= rel_sum;
                                page_cross <= rel_cross;
                                ea_valid   <= 1'b1;
                            end
                            M_STACK: begin
                                if (stack_pop) begin
                                    sp <= sp_inc;
                                    ea <= {STACK_PAGE, sp_inc};
                                end else begin
                                    sp <= sp_dec;
                                    ea <= {STACK_PAGE, sp};
                                end
                                page_cross <= 1'b0;
                                ea_valid   <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                RD_LO: begin
                    if (mem_ack) begin
                        lo_byte_q <= mem_rdata;
                        // Low byte wraps inside the page: NMOS JMP (ind) behaviour.
                        mem_addr  <= {ptr_hi_q, op_lo_q + DATA_W'(1)};
                        state     <= RD_HI;
                    end
                end
                RD_HI: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!ind_y_q) begin
                            ea         <= {mem_rdata, lo_byte_q};
                            page_cross <= 1'b0;
                            ea_valid   <= 1'b1;
                            state      <= IDLE;
                        end else if (ptr_lo_sum[DATA_W] && PAGE_PENALTY) begin
                            fix_ea_q <= ptr_sum;
                            state    <= FIX;
                        end else begin
                            ea         <= ptr_sum;
                            page_cross <= ptr_lo_sum[DATA_W];
                            ea_valid   <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                FIX: begin
                    ea         <= fix_ea_q;
                    page_cross <= 1'b1;
                    ea_valid   <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addr_gen_unit.sv
// Randomised self-checking bench for addr_gen_unit against an arithmetic reference model,
// with a wait-state memory responder serving pointer fetches.
module tb_addr_gen_unit;

    logic        CLK;
    logic        RST_N;
    logic        start;
    logic [2:0]  mode;
    logic        stack_pop;
    logic [7:0]  op_lo, op_hi, idx_x, idx_y;
    logic [15:0] pc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [15:0] ea;
    logic        ea_valid;
    logic        page_cross;
    logic        busy;
    logic [7:0]  sp;

    addr_gen_unit dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .mode(mode), .stack_pop(stack_pop),
        .op_lo(op_lo), .op_hi(op_hi), .idx_x(idx_x), .idx_y(idx_y), .pc(pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ea(ea), .ea_valid(ea_valid), .page_cross(page_cross), .busy(busy), .sp(sp)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [7:0]  mem [0:65535];
    logic [15:0] fetch_log[$];
    int          fixed_wait;
    int          checks;
    int          errors;
    int          sp_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory responder: 0..3 wait states (or fixed_wait), checks request stability.
    initial begin : responder
        bit          active;
        int          wcnt;
        logic [15:0] cur_addr;
        active    = 1'b0;
        wcnt      = 0;
        cur_addr  = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge CLK);
            mem_ack = 1'b0;
            if (!RST_N || !mem_req) begin
                active = 1'b0;
            end else begin
                if (!active) begin
                    active   = 1'b1;
                    cur_addr = mem_addr;
                    wcnt     = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
                end else begin
                    check("mem_addr_stable", 32'(mem_addr), 32'(cur_addr));
                end
                if (wcnt == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                    fetch_log.push_back(mem_addr);
                    active    = 1'b0;
                end else begin
                    wcnt--;
                end
            end
        end
    end

    // One request: model the expected result, drive start, then follow the DUT to completion.
    task automatic run_op(input int m, input bit pop, input int hi, input int lo,
                          input int x, input int y, input int pcv, input bit poke);
        int exp_ea, exp_lat, a1, a2, base, ix, off, cyc;
        bit exp_pc, exp_fix, is_mem, saw_fix, got;
        exp_ea = 0; exp_lat = 1; exp_pc = 0; exp_fix = 0; is_mem = 0; a1 = 0; a2 = 0;
        case (m)
            0: exp_ea = hi * 256 + lo;
            1, 2: begin
                ix      = (m == 1) ? x : y;
                exp_ea  = (hi * 256 + lo + ix) % 65536;
                exp_pc  = (lo + ix) > 255;
                exp_fix = exp_pc;
                exp_lat = exp_pc ? 2 : 1;
            end
            3: exp_ea = (lo + x) % 256;
            4: begin
                a1 = hi * 256 + lo;
                a2 = hi * 256 + (lo + 1) % 256;
                exp_ea = int'(mem[a2]) * 256 + int'(mem[a1]);
                is_mem = 1; exp_lat = -1;
            end
            5: begin
                a1 = lo;
                a2 = (lo + 1) % 256;
                base    = int'(mem[a2]) * 256 + int'(mem[a1]);
                exp_ea  = (base + y) % 65536;
                exp_pc  = (int'(mem[a1]) + y) > 255;
                exp_fix = exp_pc;
                is_mem = 1; exp_lat = -1;
            end
            6: begin
                off    = (lo < 128) ? lo : lo - 256;
                exp_ea = (pcv + off + 65536) % 65536;
                exp_pc = (exp_ea / 256) != (pcv / 256);
            end
            default: begin
                if (pop) begin
                    sp_m   = (sp_m + 1) % 256;
                    exp_ea = 256 + sp_m;
                end else begin
                    exp_ea = 256 + sp_m;
                    sp_m   = (sp_m + 255) % 256;
                end
            end
        endcase

        fetch_log.delete();
        mode = 3'(m); stack_pop = pop; op_hi = 8'(hi); op_lo = 8'(lo);
        idx_x = 8'(x); idx_y = 8'(y); pc = 16'(pcv);
        start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;

        cyc = 0; got = 0; saw_fix = 0;
        while (!got && cyc < 100) begin
            @(negedge CLK);
            start = 1'b0;
            cyc++;
            if (ea_valid) begin
                got = 1;
            end else begin
                check("busy_while_pending", 32'(busy), 32'(1));
                if (!mem_req) saw_fix = 1;
                if (poke) begin
                    start = 1'b1;
                    mode  = 3'($urandom);
                    stack_pop = 1'($urandom);
                    op_lo = 8'($urandom); op_hi = 8'($urandom);
                    idx_x = 8'($urandom); idx_y = 8'($urandom); pc = 16'($urandom);
                end
            end
        end
        check("completion_timeout", 32'(got), 32'(1));
        if (got) begin
            check("ea", 32'(ea), 32'(exp_ea));
            check("page_cross", 32'(page_cross), 32'(exp_pc));
            check("sp", 32'(sp), 32'(sp_m));
            check("busy_at_done", 32'(busy), 32'(0));
            check("fix_cycle", 32'(saw_fix), 32'(exp_fix));
            if (exp_lat > 0) check("latency", 32'(cyc), 32'(exp_lat));
            if (is_mem) begin
                check("fetch_count", 32'(fetch_log.size()), 32'(2));
                if (fetch_log.size() == 2) begin
                    check("fetch_lo_addr", 32'(fetch_log[0]), 32'(a1));
                    check("fetch_hi_addr", 32'(fetch_log[1]), 32'(a2));
                end
            end
        end
        @(negedge CLK);
        check("valid_single_pulse", 32'(ea_valid), 32'(0));
        check("ea_held", 32'(ea), 32'(exp_ea));
    endtask

    initial begin
        checks = 0; errors = 0; sp_m = 255; fixed_wait = -1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h30FF] = 8'h80; mem[16'h3000] = 8'h50; mem[16'h3100] = 8'h99;
        mem[16'h00FF] = 8'hF0; mem[16'h0000] = 8'h20;
        start = 1'b0; mode = '0; stack_pop = 1'b0; op_lo = '0; op_hi = '0;
        idx_x = '0; idx_y = '0; pc = '0;

        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_ea", 32'(ea), 32'(0));
        check("rst_ea_valid", 32'(ea_valid), 32'(0));
        check("rst_page_cross", 32'(page_cross), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_mem_req", 32'(mem_req), 32'(0));
        check("rst_mem_addr", 32'(mem_addr), 32'(0));
        check("rst_sp", 32'(sp), 32'(8'hFF));
        RST_N = 1'b1;
        @(negedge CLK);

        run_op(0, 0, 'h12, 'h34, 0, 0, 0, 0);

        // Asynchronous reset in the middle of an IND_Y pointer fetch.
        fixed_wait = 5;
        mode = 3'd5; op_lo = 8'hFF; start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        repeat (2) @(negedge CLK);
        check("ind_y_fetching", 32'(mem_req), 32'(1));
        RST_N = 1'b0;
        #1;
        check("midrst_ea", 32'(ea), 32'(0));
        check("midrst_mem_req", 32'(mem_req), 32'(0));
        check("midrst_sp", 32'(sp), 32'(8'hFF));
        check("midrst_busy", 32'(busy), 32'(0));
        sp_m = 255;
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        fixed_wait = -1;

        run_op(1, 0, 'h12, 'hF0, 'h20, 0, 0, 0);
        run_op(1, 0, 'h12, 'hF0, 'h0F, 0, 0, 0);
        run_op(2, 0, 'h40, 'h80, 0, 'h90, 0, 0);
        run_op(3, 0, 0, 'hF0, 'h20, 0, 0, 0);
        run_op(6, 0, 0, 'h20, 0, 0, 'h10F0, 0);
        run_op(6, 0, 0, 'h80, 0, 0, 'h10F0, 0);
        fixed_wait = 3;
        run_op(4, 0, 'h30, 'hFF, 0, 0, 0, 0);
        fixed_wait = 1;
        run_op(5, 0, 0, 'hFF, 0, 'h20, 0, 1);
        fixed_wait = -1;
        repeat (3) run_op(7, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) run_op(7, 1, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            run_op(int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), int'($urandom_range(0, 65535)),
                   ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
